// File: rtl/ofdm_decode_sequencer_pkg.sv
// Shared types and constants for the OFDM decode phase sequencer.
// Optional HT-SIG support is selected with the DECODE_SEQ_HT_EN macro.
package ofdm_decode_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CLR_SIG  = 4'd1,
        ST_SIG      = 4'd2,
        ST_CLR_HT   = 4'd3,
        ST_HTSIG    = 4'd4,
        ST_CLR_DATA = 4'd5,
        ST_DATA     = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERR      = 4'd8
    } seq_state_e;

    localparam logic [2:0]  ERR_NONE          = 3'd0;
    localparam logic [2:0]  ERR_PARITY        = 3'd1;
    localparam logic [2:0]  ERR_RATE          = 3'd2;
    localparam logic [2:0]  ERR_LEN           = 3'd3;
    localparam logic [2:0]  ERR_CRC           = 3'd4;
    localparam logic [2:0]  ERR_TIMEOUT       = 3'd5;
    localparam logic [19:0] SIG_BITS          = 20'd24;
    localparam logic [19:0] HTSIG_BITS        = 20'd48;
    localparam logic [19:0] SERVICE_TAIL_BITS = 20'd22;
    localparam logic [7:0]  RATE_6M           = 8'h0B;

    // DATA bit budget: SERVICE + tail/pad bits plus eight bits per PSDU byte.
    function automatic logic [19:0] data_bits(input logic [15:0] len);
        return SERVICE_TAIL_BITS + {1'b0, len, 3'b000};
    endfunction

    function automatic logic is_clr(input seq_state_e st);
        return (st == ST_CLR_SIG) || (st == ST_CLR_HT) || (st == ST_CLR_DATA);
    endfunction

    function automatic logic is_phase(input seq_state_e st);
        return (st == ST_SIG) || (st == ST_HTSIG) || (st == ST_DATA);
    endfunction

endpackage

// File: rtl/ofdm_decode_sequencer_watchdog.sv
// Decode-phase inactivity watchdog: counts enabled cycles since the last clear
// and flags expiry once WDOG_CYCLES cycles have passed without one.
module ofdm_decode_sequencer_watchdog #(
    parameter logic [15:0] WDOG_CYCLES = 16'd8000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Saturating idle-cycle counter next value
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 16'd0;
        end else if (enable && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable & ~clear & (cnt_q >= (WDOG_CYCLES - 16'd1));

endmodule

// File: rtl/ofdm_decode_sequencer.sv
// Per-packet SIG -> (HT-SIG) -> DATA phase controller for the OFDM decoder.
// Define DECODE_SEQ_HT_EN to enable the HT-SIG phase; otherwise legacy only.
module ofdm_decode_sequencer
    import ofdm_decode_sequencer_pkg::*;
#(
    parameter logic [15:0] WDOG_CYCLES = 16'd8000,
    parameter logic [15:0] MAX_LEN     = 16'd4095
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        sig_valid,
    input  logic        sig_parity_ok,
    input  logic [3:0]  sig_rate,
    input  logic [11:0] sig_len,
    input  logic        ht_detected,
    input  logic        htsig_valid,
    input  logic        htsig_crc_ok,
    input  logic [6:0]  ht_mcs,
    input  logic [15:0] ht_len,
    input  logic        byte_strobe,
    output logic        dec_reset,
    output logic        dec_enable,
    output logic [7:0]  dec_rate,
    output logic        dec_do_descr,
    output logic [19:0] dec_num_bits,
    output logic [15:0] byte_count,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic [2:0]  err_code
);
    seq_state_e  state_q, state_d;
    logic        dec_reset_q, dec_reset_d;
    logic        dec_enable_q, dec_enable_d;
    logic [7:0]  dec_rate_q, dec_rate_d;
    logic        dec_descr_q, dec_descr_d;
    logic [19:0] dec_num_bits_q, dec_num_bits_d;
    logic [15:0] byte_count_q, byte_count_d;
    logic [15:0] len_q, len_d;
    logic        pkt_done_q, pkt_done_d;
    logic        pkt_err_q, pkt_err_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [2:0]  err_sel_s;
    logic        aborted_s;
    logic        strobe_s;
    logic        wd_expire_s;

    assign strobe_s = byte_strobe & is_phase(state_q);

    ofdm_decode_sequencer_watchdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (is_clr(state_q) | strobe_s),
        .enable  (is_phase(state_q)),
        .expire  (wd_expire_s)
    );

`ifndef DECODE_SEQ_HT_EN
    logic unused_ht_s;
    assign unused_ht_s = ^{ht_detected, htsig_valid, htsig_crc_ok, ht_mcs, ht_len, MAX_LEN};
`endif

    // Next state plus the rate/budget/length loaded for the upcoming phase
    always_comb begin
        state_d        = state_q;
        err_sel_s      = ERR_NONE;
        aborted_s      = 1'b0;
        dec_rate_d     = dec_rate_q;
        dec_num_bits_d = dec_num_bits_q;
        len_d          = len_q;
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            aborted_s = 1'b1;
        end else if (wd_expire_s) begin
            state_d   = ST_ERR;
            err_sel_s = ERR_TIMEOUT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d        = ST_CLR_SIG;
                        dec_rate_d     = RATE_6M;
                        dec_num_bits_d = SIG_BITS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CLR_SIG:  state_d = ST_SIG;
                ST_SIG: begin
                    if (!sig_valid) begin
                        state_d = ST_SIG;
                    end else if (!sig_parity_ok) begin
                        state_d   = ST_ERR;
                        err_sel_s = ERR_PARITY;
                    end else if (!sig_rate[3]) begin
                        state_d   = ST_ERR;
                        err_sel_s = ERR_RATE;
                    end else if (sig_len == 12'd0) begin
                        state_d   = ST_ERR;
                        err_sel_s = ERR_LEN;
`ifdef DECODE_SEQ_HT_EN
                    end else if (ht_detected) begin
                        state_d        = ST_CLR_HT;
                        dec_rate_d     = RATE_6M;
                        dec_num_bits_d = HTSIG_BITS;
`endif
                    end else begin
                        state_d        = ST_CLR_DATA;
                        dec_rate_d     = {4'h0, sig_rate};
                        len_d          = {4'h0, sig_len};
                        dec_num_bits_d = data_bits({4'h0, sig_len});
                    end
                end
                ST_CLR_HT:   state_d = ST_HTSIG;
                ST_HTSIG: begin
`ifdef DECODE_SEQ_HT_EN
                    if (!htsig_valid) begin
                        state_d = ST_HTSIG;
                    end else if (!htsig_crc_ok) begin
                        state_d   = ST_ERR;
                        err_sel_s = ERR_CRC;
                    end else if (ht_mcs > 7'd7) begin
                        state_d   = ST_ERR;
                        err_sel_s = ERR_RATE;
                    end else if ((ht_len == 16'd0) || (ht_len > MAX_LEN)) begin
                        state_d   = ST_ERR;
                        err_sel_s = ERR_LEN;
                    end else begin
                        state_d        = ST_CLR_DATA;
                        dec_rate_d     = {1'b1, ht_mcs};
                        len_d          = ht_len;
                        dec_num_bits_d = data_bits(ht_len);
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                ST_CLR_DATA: state_d = ST_DATA;
                ST_DATA: begin
                    if (byte_count_q == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DONE:     state_d = ST_IDLE;
                ST_ERR:      state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs registered from the next state so they line up with it
    always_comb begin
        dec_reset_d  = aborted_s | is_clr(state_d);
        dec_enable_d = is_phase(state_d);
        dec_descr_d  = (state_d == ST_CLR_DATA) || (state_d == ST_DATA);
        pkt_done_d   = (state_d == ST_DONE);
        pkt_err_d    = (state_d == ST_ERR);
        if (state_d == ST_ERR) begin
            err_code_d = err_sel_s;
        end else if ((state_q == ST_IDLE) && (state_d == ST_CLR_SIG)) begin
            err_code_d = ERR_NONE;
        end else begin
            err_code_d = err_code_q;
        end
        if (is_clr(state_q)) begin
            byte_count_d = 16'd0;
        end else if (strobe_s && (byte_count_q != 16'hFFFF)) begin
            byte_count_d = byte_count_q + 16'd1;
        end else begin
            byte_count_d = byte_count_q;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            dec_reset_q    <= 1'b1;
            dec_enable_q   <= 1'b0;
            dec_rate_q     <= RATE_6M;
            dec_descr_q    <= 1'b0;
            dec_num_bits_q <= 20'd0;
            byte_count_q   <= 16'd0;
            len_q          <= 16'd0;
            pkt_done_q     <= 1'b0;
            pkt_err_q      <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            dec_reset_q    <= dec_reset_d;
            dec_enable_q   <= dec_enable_d;
            dec_rate_q     <= dec_rate_d;
            dec_descr_q    <= dec_descr_d;
            dec_num_bits_q <= dec_num_bits_d;
            byte_count_q   <= byte_count_d;
            len_q          <= len_d;
            pkt_done_q     <= pkt_done_d;
            pkt_err_q      <= pkt_err_d;
            err_code_q     <= err_code_d;
        end
    end

    assign dec_reset    = dec_reset_q;
    assign dec_enable   = dec_enable_q;
    assign dec_rate     = dec_rate_q;
    assign dec_do_descr = dec_descr_q;
    assign dec_num_bits = dec_num_bits_q;
    assign byte_count   = byte_count_q;
    assign pkt_done     = pkt_done_q;
    assign pkt_err      = pkt_err_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_ofdm_decode_sequencer.sv
// Self-checking bench for ofdm_decode_sequencer: vector table, random legacy
// packets against a reference model, and hand-written corner sequences.
module tb_ofdm_decode_sequencer;
    localparam int WDOG = 300;

    logic        clock, reset_n, start, abort, sig_valid, sig_parity_ok;
    logic [3:0]  sig_rate;
    logic [11:0] sig_len;
    logic        ht_detected, htsig_valid, htsig_crc_ok;
    logic [6:0]  ht_mcs;
    logic [15:0] ht_len;
    logic        byte_strobe;
    logic        dec_reset, dec_enable, dec_do_descr, pkt_done, pkt_err;
    logic [7:0]  dec_rate;
    logic [19:0] dec_num_bits;
    logic [15:0] byte_count;
    logic [2:0]  err_code;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    ofdm_decode_sequencer #(.WDOG_CYCLES(16'd300), .MAX_LEN(16'd4095)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .sig_valid(sig_valid), .sig_parity_ok(sig_parity_ok), .sig_rate(sig_rate),
        .sig_len(sig_len), .ht_detected(ht_detected), .htsig_valid(htsig_valid),
        .htsig_crc_ok(htsig_crc_ok), .ht_mcs(ht_mcs), .ht_len(ht_len),
        .byte_strobe(byte_strobe), .dec_reset(dec_reset), .dec_enable(dec_enable),
        .dec_rate(dec_rate), .dec_do_descr(dec_do_descr), .dec_num_bits(dec_num_bits),
        .byte_count(byte_count), .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pkt_done) done_cnt++;
        if (pkt_err) err_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    typedef struct {
        logic        par;
        logic [3:0]  rate;
        logic [11:0] len;
        logic [2:0]  exp_err;
        logic [19:0] exp_bits;
        int          gmax;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rules for a legacy SIG field: outcome code and DATA bit budget.
    function automatic void model_sig(input logic par, input logic [3:0] rate, input logic [11:0] len,
                                      output logic [2:0] err, output logic [19:0] bits);
        if (!par) err = 3'd1;
        else if (int'(rate) < 8) err = 3'd2;
        else if (len == 12'd0) err = 3'd3;
        else err = 3'd0;
        bits = 20'(22 + 8 * int'(len));
    endfunction

    task automatic finish_err(input logic [2:0] code);
        check("err_pulse", 32'(pkt_err), 32'd1);
        check("err_code", 32'(err_code), 32'(code));
        check("err_enable", 32'(dec_enable), 32'd0);
        @(negedge clock);
        check("err_single", 32'(pkt_err), 32'd0);
        check("err_hold", 32'(err_code), 32'(code));
    endtask

    task automatic finish_data(input logic [7:0] exp_rate, input logic [19:0] exp_bits,
                               input int len, input int gmax);
        check("clr_data_reset", 32'(dec_reset), 32'd1);
        check("data_rate", 32'(dec_rate), 32'(exp_rate));
        check("data_bits", 32'(dec_num_bits), 32'(exp_bits));
        @(negedge clock);
        check("data_enable", 32'(dec_enable), 32'd1);
        check("data_descr", 32'(dec_do_descr), 32'd1);
        check("data_count0", 32'(byte_count), 32'd0);
        for (int i = 0; i < len; i++) begin
            byte_strobe = 1'b1;
            @(negedge clock);
            byte_strobe = 1'b0;
            if (i != len - 1) repeat ($urandom_range(gmax, 0)) @(negedge clock);
        end
        check("byte_count", 32'(byte_count), 32'(len));
        check("done_early", 32'(pkt_done), 32'd0);
        @(negedge clock);
        check("pkt_done", 32'(pkt_done), 32'd1);
        check("done_enable", 32'(dec_enable), 32'd0);
        @(negedge clock);
        check("done_single", 32'(pkt_done), 32'd0);
    endtask

    task automatic start_pkt();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("clr_sig_reset", 32'(dec_reset), 32'd1);
        check("clr_sig_enable", 32'(dec_enable), 32'd0);
        check("err_code_cleared", 32'(err_code), 32'd0);
        @(negedge clock);
        check("sig_enable", 32'(dec_enable), 32'd1);
        check("sig_rate", 32'(dec_rate), 32'h0B);
        check("sig_bits", 32'(dec_num_bits), 32'd24);
    endtask

    task automatic do_legacy(input logic par, input logic [3:0] rate, input logic [11:0] len,
                             input logic ht, input logic [2:0] exp_err,
                             input logic [19:0] exp_bits, input int gmax);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_pkt();
        sig_valid = 1'b1; sig_parity_ok = par; sig_rate = rate; sig_len = len; ht_detected = ht;
        @(negedge clock);
        sig_valid = 1'b0; ht_detected = 1'b0;
        if (exp_err != 3'd0) finish_err(exp_err);
        else finish_data({4'h0, rate}, exp_bits, int'(len), gmax);
        check("done_count", 32'(done_cnt - d0), (exp_err == 3'd0) ? 32'd1 : 32'd0);
        check("err_count", 32'(err_cnt - e0), (exp_err != 3'd0) ? 32'd1 : 32'd0);
        @(negedge clock);
    endtask

    task automatic enter_data(input logic [11:0] len);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        sig_valid = 1'b1; sig_parity_ok = 1'b1; sig_rate = 4'hD; sig_len = len;
        @(negedge clock);
        sig_valid = 1'b0;
        @(negedge clock);
        check("enter_data_enable", 32'(dec_enable), 32'd1);
    endtask

`ifdef DECODE_SEQ_HT_EN
    task automatic do_ht(input logic crc, input logic [6:0] mcs, input logic [15:0] hlen);
        logic [2:0] exp_err;
        int d0, e0;
        if (!crc) exp_err = 3'd4;
        else if (int'(mcs) > 7) exp_err = 3'd2;
        else if (hlen == 16'd0 || int'(hlen) > 4095) exp_err = 3'd3;
        else exp_err = 3'd0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_pkt();
        sig_valid = 1'b1; sig_parity_ok = 1'b1; sig_rate = 4'hD; sig_len = 12'd10; ht_detected = 1'b1;
        @(negedge clock);
        sig_valid = 1'b0; ht_detected = 1'b0;
        check("clr_ht_reset", 32'(dec_reset), 32'd1);
        check("ht_rate", 32'(dec_rate), 32'h0B);
        check("ht_bits", 32'(dec_num_bits), 32'd48);
        @(negedge clock);
        check("htsig_enable", 32'(dec_enable), 32'd1);
        htsig_valid = 1'b1; htsig_crc_ok = crc; ht_mcs = mcs; ht_len = hlen;
        @(negedge clock);
        htsig_valid = 1'b0;
        if (exp_err != 3'd0) finish_err(exp_err);
        else finish_data({1'b1, mcs}, 20'(22 + 8 * int'(hlen)), int'(hlen), 1);
        check("ht_done_count", 32'(done_cnt - d0), (exp_err == 3'd0) ? 32'd1 : 32'd0);
        check("ht_err_count", 32'(err_cnt - e0), (exp_err != 3'd0) ? 32'd1 : 32'd0);
        @(negedge clock);
    endtask
`endif

    initial begin
        int d0, e0, n;
        logic        rp;
        logic [3:0]  rr;
        logic [11:0] rl;
        logic [2:0]  me;
        logic [19:0] mb;

        vecs[0] = '{1'b1, 4'hD, 12'd100,  3'd0, 20'd822,   3};
        vecs[1] = '{1'b0, 4'hD, 12'd10,   3'd1, 20'd0,     0};
        vecs[2] = '{1'b1, 4'h3, 12'd10,   3'd2, 20'd0,     0};
        vecs[3] = '{1'b1, 4'hB, 12'd0,    3'd3, 20'd0,     0};
        vecs[4] = '{1'b1, 4'h8, 12'd1,    3'd0, 20'd30,    2};
        vecs[5] = '{1'b1, 4'hF, 12'd4095, 3'd0, 20'd32782, 0};
        vecs[6] = '{1'b0, 4'h3, 12'd0,    3'd1, 20'd0,     0};
        vecs[7] = '{1'b1, 4'h7, 12'd0,    3'd2, 20'd0,     0};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; sig_valid = 1'b0; sig_parity_ok = 1'b0;
        sig_rate = 4'h0; sig_len = 12'd0; ht_detected = 1'b0; htsig_valid = 1'b0;
        htsig_crc_ok = 1'b0; ht_mcs = 7'd0; ht_len = 16'd0; byte_strobe = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_dec_reset", 32'(dec_reset), 32'd1);
        check("rst_enable", 32'(dec_enable), 32'd0);
        check("rst_rate", 32'(dec_rate), 32'h0B);
        check("rst_bits", 32'(dec_num_bits), 32'd0);
        check("rst_descr", 32'(dec_do_descr), 32'd0);
        check("rst_count", 32'(byte_count), 32'd0);
        check("rst_pulses", 32'({pkt_done, pkt_err}), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_dec_reset", 32'(dec_reset), 32'd0);
        byte_strobe = 1'b1;
        @(negedge clock);
        byte_strobe = 1'b0;
        check("idle_strobe_ignored", 32'(byte_count), 32'd0);

        for (int i = 0; i < 8; i++)
            do_legacy(vecs[i].par, vecs[i].rate, vecs[i].len, 1'b0,
                      vecs[i].exp_err, vecs[i].exp_bits, vecs[i].gmax);

        for (int i = 0; i < 20; i++) begin
            rp = ($urandom % 8) != 0;
            rr = 4'($urandom % 16);
            rl = 12'($urandom_range(30, 0));
            model_sig(rp, rr, rl, me, mb);
            do_legacy(rp, rr, rl, 1'b0, me, mb, 3);
        end

        // abort halfway through DATA, with a stray start that must be ignored
        enter_data(12'd100);
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 50; i++) begin
            byte_strobe = 1'b1;
            @(negedge clock);
            byte_strobe = 1'b0;
        end
        check("abort_count50", 32'(byte_count), 32'd50);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_ignored_enable", 32'(dec_enable), 32'd1);
        check("start_ignored_reset", 32'(dec_reset), 32'd0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_dec_reset", 32'(dec_reset), 32'd1);
        check("abort_enable", 32'(dec_enable), 32'd0);
        @(negedge clock);
        check("abort_reset_single", 32'(dec_reset), 32'd0);
        repeat (3) @(negedge clock);
        check("abort_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        do_legacy(1'b1, 4'hD, 12'd20, 1'b0, 3'd0, 20'd182, 1);

        // watchdog in DATA with no byte strobes
        enter_data(12'd5);
        n = 0;
        while (n < WDOG + 20 && !pkt_err) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n < WDOG - 2 || n > WDOG + 2) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected about %0d", n, WDOG);
        end
        check("timeout_err_code", 32'(err_code), 32'd5);
        check("timeout_enable", 32'(dec_enable), 32'd0);
        repeat (2) @(negedge clock);

        // asynchronous reset mid-DATA
        enter_data(12'd20);
        for (int i = 0; i < 5; i++) begin
            byte_strobe = 1'b1;
            @(negedge clock);
            byte_strobe = 1'b0;
        end
        d0 = done_cnt; e0 = err_cnt;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_enable", 32'(dec_enable), 32'd0);
        check("async_rst_dec_reset", 32'(dec_reset), 32'd1);
        check("async_rst_count", 32'(byte_count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("async_rst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        do_legacy(1'b1, 4'h9, 12'd3, 1'b0, 3'd0, 20'd46, 1);

`ifdef DECODE_SEQ_HT_EN
        do_ht(1'b1, 7'd3, 16'd200);
        do_ht(1'b0, 7'd3, 16'd200);
        do_ht(1'b1, 7'd8, 16'd200);
        do_ht(1'b1, 7'd2, 16'd0);
        do_ht(1'b1, 7'd2, 16'd4096);
`else
        do_legacy(1'b1, 4'hD, 12'd10, 1'b1, 3'd0, 20'd102, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
